// File: rtl/seq_divider_if.sv
// seq_divider_if
//   Request/response bundle for the sequential divider.
//   master : drives i_start, i_signed, i_flush, i_dividend, i_divisor;
//            receives o_busy, o_done, o_quotient, o_remainder, o_div_zero.
//   slave  : the divider side of the same signals.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             i_start;
    logic             i_signed;
    logic             i_flush;
    logic [WIDTH-1:0] i_dividend;
    logic [WIDTH-1:0] i_divisor;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_quotient;
    logic [WIDTH-1:0] o_remainder;
    logic             o_div_zero;

    modport master (
        output i_start, i_signed, i_flush, i_dividend, i_divisor,
        input  o_busy, o_done, o_quotient, o_remainder, o_div_zero
    );

    modport slave (
        input  i_start, i_signed, i_flush, i_dividend, i_divisor,
        output o_busy, o_done, o_quotient, o_remainder, o_div_zero
    );
endinterface

// File: rtl/seq_divider.sv
// seq_divider
//   Multi-cycle restoring divider (one quotient bit per clock) for DIV/DIVU.
//   Ports:
//     i_clk  clock, rising edge
//     i_rst  asynchronous active-high reset
//     bus    seq_divider_if.slave: start/signed/flush/operands in,
//            busy/done/quotient/remainder/div_zero out
//   Build option: DIVIDER_SIGNED_EN enables signed division when i_signed=1;
//   without it every operation is unsigned and i_signed is ignored.
//
//   state | meaning
//   IDLE  | waiting for i_start
//   CALC  | shifting/subtracting, o_busy high, WIDTH steps
//   DONE  | one cycle, o_done high, results valid; may accept a new start
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [CW-1:0]    r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    logic             w_signed_op;
    logic             w_neg_dvd;
    logic             w_neg_dvs;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

`ifdef DIVIDER_SIGNED_EN
    assign w_signed_op = bus.i_signed;
`else
    // Signed mode is compiled out; i_signed is deliberately masked.
    assign w_signed_op = bus.i_signed & 1'b0;
`endif

    assign w_neg_dvd = w_signed_op & bus.i_dividend[WIDTH-1];
    assign w_neg_dvs = w_signed_op & bus.i_divisor[WIDTH-1];
    // The magnitude of MIN is 2^(WIDTH-1), which still fits unsigned.
    assign w_dvd_mag = w_neg_dvd ? (~bus.i_dividend + WIDTH'(1)) : bus.i_dividend;
    assign w_dvs_mag = w_neg_dvs ? (~bus.i_divisor + WIDTH'(1)) : bus.i_divisor;

    // Trial subtraction on WIDTH+1 bits: the shifted remainder can reach
    // 2*divisor-1, which needs one extra bit.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_ge      = (w_shift >= {1'b0, r_dvs});
    assign w_rem_nxt = w_ge ? (w_shift[WIDTH-1:0] - r_dvs) : w_shift[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_cnt       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_div_zero  <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            case (r_state)
                CALC: begin
                    if (bus.i_flush) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt - CW'(1);
                        // Last step: publish the results straight from the
                        // step logic so DONE follows the WIDTH-th edge.
                        if (r_cnt == CW'(1)) begin
                            r_state     <= DONE;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_div_zero  <= 1'b0;
                            r_quotient  <= r_neg_q ? (~w_quo_nxt + WIDTH'(1)) : w_quo_nxt;
                            r_remainder <= r_neg_r ? (~w_rem_nxt + WIDTH'(1)) : w_rem_nxt;
                        end
                    end
                end
                default: begin
                    // IDLE or DONE: o_done lasts one cycle unless a new
                    // divide-by-zero request re-enters DONE immediately.
                    r_done <= 1'b0;
                    if ((r_state == DONE) && bus.i_flush) begin
                        r_state <= IDLE;
                    end else if (bus.i_start) begin
                        if (bus.i_divisor == '0) begin
                            r_state     <= DONE;
                            r_done      <= 1'b1;
                            r_div_zero  <= 1'b1;
                            r_quotient  <= '1;
                            r_remainder <= bus.i_dividend;
                        end else begin
                            r_state <= CALC;
                            r_busy  <= 1'b1;
                            r_rem   <= '0;
                            r_quo   <= w_dvd_mag;
                            r_dvs   <= w_dvs_mag;
                            r_cnt   <= CW'(WIDTH);
                            r_neg_q <= w_neg_dvd ^ w_neg_dvs;
                            r_neg_r <= w_neg_dvd;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.o_busy      = r_busy;
    assign bus.o_done      = r_done;
    assign bus.o_quotient  = r_quotient;
    assign bus.o_remainder = r_remainder;
    assign bus.o_div_zero  = r_div_zero;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider
//   Directed stimulus with a result scoreboard: each accepted request pushes
//   its hand-computed result; a monitor pops and compares on every o_done.
module tb_seq_divider;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every o_done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.o_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: got done with q=0x%08h r=0x%08h, expected none",
                         bus.o_quotient, bus.o_remainder);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("quotient",  bus.o_quotient,  e.q);
                chk("remainder", bus.o_remainder, e.r);
                chk("div_zero",  W'(bus.o_div_zero), W'(e.dz));
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
        exp_t e;
        e.q = q; e.r = r; e.dz = dz;
        sb_q.push_back(e);
    endtask

    // Pulses i_start for one cycle; returns 1 time unit after the accepting edge.
    task automatic start_op(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input logic sgn);
        @(posedge clk); #1;
        bus.i_start    = 1'b1;
        bus.i_dividend = dvd;
        bus.i_divisor  = dvs;
        bus.i_signed   = sgn;
        @(posedge clk); #1;
        bus.i_start    = 1'b0;
    endtask

    // Samples at negedges until o_done; counts busy cycles and cycles waited.
    task automatic wait_done(input string name, output int busy_n, output int waited);
        busy_n = 0;
        waited = 0;
        forever begin
            @(negedge clk);
            if (bus.o_done === 1'b1) break;
            if (bus.o_busy === 1'b1) busy_n++;
            waited++;
            if (waited > 200) begin
                n_total++;
                $display("FAIL %s_timeout: got no done after %0d cycles, expected done", name, waited);
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                          input logic sgn, input logic [W-1:0] q, input logic [W-1:0] r,
                          input logic dz, input int lat);
        int b, w;
        push_exp(q, r, dz);
        start_op(dvd, dvs, sgn);
        wait_done(name, b, w);
        chk({name, "_latency"}, W'(w), W'(lat));
        chk({name, "_busy"},    W'(b), W'(lat));
        @(negedge clk);
        chk({name, "_done_pulse"}, W'(bus.o_done), W'(0));
    endtask

    initial begin
        int b, w;
        bit done_seen;
        bus.i_start    = 1'b0;
        bus.i_signed   = 1'b0;
        bus.i_flush    = 1'b0;
        bus.i_dividend = '0;
        bus.i_divisor  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", W'(bus.o_busy), W'(0));
        chk("rst_done", W'(bus.o_done), W'(0));
        chk("rst_dz",   W'(bus.o_div_zero), W'(0));
        chk("rst_q",    bus.o_quotient, W'(0));
        chk("rst_r",    bus.o_remainder, W'(0));

        run_op("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 32);
        run_op("div0",   32'd5,   32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0);
        run_op("u9_3",   32'd9,   32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 32);
`ifdef DIVIDER_SIGNED_EN
        run_op("s_m7_2",  32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 32);
        run_op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 32);
        run_op("s_7_m2",  32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 32);
`else
        run_op("s_m7_2",  32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, 32);
        run_op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, 32);
`endif
        run_op("u9_3b", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 32);

        // Flush in CALC cycle 10, with a competing start in the same cycle.
        start_op(32'd100, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        bus.i_flush    = 1'b1;
        bus.i_start    = 1'b1;
        bus.i_dividend = 32'd1;
        bus.i_divisor  = 32'd1;
        @(posedge clk); #1;
        bus.i_flush = 1'b0;
        bus.i_start = 1'b0;
        @(negedge clk);
        chk("flush_busy", W'(bus.o_busy), W'(0));
        chk("flush_done", W'(bus.o_done), W'(0));
        chk("flush_q",    bus.o_quotient, 32'd3);
        chk("flush_r",    bus.o_remainder, 32'd0);
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.o_done === 1'b1 || bus.o_busy === 1'b1) done_seen = 1'b1;
        end
        chk("flush_quiet", W'(done_seen), W'(0));
        run_op("u50_5", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, 32);

        // Back-to-back: start held high; operands changed during CALC are
        // ignored until the DONE cycle accepts them.
        push_exp(32'd100, 32'd0, 1'b0);
        push_exp(32'd9,   32'd5, 1'b0);
        @(posedge clk); #1;
        bus.i_start    = 1'b1;
        bus.i_signed   = 1'b0;
        bus.i_dividend = 32'd1000;
        bus.i_divisor  = 32'd10;
        @(posedge clk); #1;
        bus.i_dividend = 32'd77;
        bus.i_divisor  = 32'd8;
        wait_done("b2b_first", b, w);
        chk("b2b_first_latency", W'(w), W'(32));
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        wait_done("b2b_second", b, w);
        chk("b2b_second_busy", W'(b), W'(32));
        chk("b2b_second_latency", W'(w), W'(32));
        @(negedge clk);
        chk("b2b_done_pulse", W'(bus.o_done), W'(0));

        // Asynchronous reset mid-CALC, away from any clock edge.
        start_op(32'd100, 32'd7, 1'b0);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy", W'(bus.o_busy), W'(0));
        chk("arst_done", W'(bus.o_done), W'(0));
        chk("arst_dz",   W'(bus.o_div_zero), W'(0));
        chk("arst_q",    bus.o_quotient, W'(0));
        chk("arst_r",    bus.o_remainder, W'(0));
        @(posedge clk); #1 rst = 1'b0;
        run_op("post_rst", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 32);

        repeat (5) @(negedge clk);
        chk("sb_empty", W'(sb_q.size()), W'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got still running, expected finish");
        $fatal(1);
    end
endmodule
